// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite channel bundle between an interconnect master and the register slave.
// Latency: none, this is wiring only.
// Backpressure: carries the VALID/READY pairs of all five channels unchanged.
interface axi4lite_reg_slave_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  AW_VALID;
    logic                  AW_READY;
    logic [ADDR_W-1:0]     AW_ADDR;
    logic [2:0]            AW_PROT;
    logic                  W_VALID;
    logic                  W_READY;
    logic [DATA_W-1:0]     W_DATA;
    logic [DATA_W/8-1:0]   W_STRB;
    logic                  B_VALID;
    logic                  B_READY;
    logic [1:0]            B_RESP;
    logic                  AR_VALID;
    logic                  AR_READY;
    logic [ADDR_W-1:0]     AR_ADDR;
    logic [2:0]            AR_PROT;
    logic                  R_VALID;
    logic                  R_READY;
    logic [DATA_W-1:0]     R_DATA;
    logic [1:0]            R_RESP;

    modport slave (
        input  AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport master (
        output AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank with byte strobes, decoupled AW/W capture and SLVERR on out-of-range index.
// Latency: B one cycle after the later of AW/W handshakes; R one cycle after AR handshake.
// Backpressure: B/R held stable until READY; AW/W/AR stalled while a response is pending.
// Optional feature macro AXI4L_WR_PULSE_EN adds the per-register WR_PULSE output.
module axi4lite_reg_slave #(
    parameter int              ADDR_W    = 12,
    parameter int              DATA_W    = 32,
    parameter int              NUM_REGS  = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}}
) (
    input  logic                   A_CLK,
    input  logic                   A_RST,
    axi4lite_reg_slave_if.slave    s_axi
`ifdef AXI4L_WR_PULSE_EN
    ,
    output logic [NUM_REGS-1:0]    WR_PULSE
`endif
);
    localparam int ALSB   = $clog2(DATA_W/8);
    localparam int NBYTES = DATA_W/8;
    localparam int AIDX_W = ADDR_W - ALSB;
    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [AIDX_W:0] LIMIT = NUM_REGS[AIDX_W:0];
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t             r_wstate;
    rstate_t             r_rstate;
    logic                r_live;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_aw_held;
    logic [AIDX_W-1:0]   r_aw_idx;
    logic                r_w_held;
    logic [DATA_W-1:0]   r_w_data;
    logic [NBYTES-1:0]   r_w_strb;
    logic                r_b_valid;
    logic [1:0]          r_b_resp;
    logic                r_r_valid;
    logic [DATA_W-1:0]   r_r_data;
    logic [1:0]          r_r_resp;
`ifdef AXI4L_WR_PULSE_EN
    logic [NUM_REGS-1:0] r_wr_pulse;
`endif

    logic                w_aw_rdy, w_w_rdy, w_ar_rdy;
    logic                w_aw_hs, w_w_hs, w_ar_hs;
    logic                w_commit, w_c_ok, w_ar_ok;
    logic [AIDX_W-1:0]   w_c_idx, w_ar_idx;
    logic [DATA_W-1:0]   w_c_data;
    logic [NBYTES-1:0]   w_c_strb;
    logic                w_unused;

    // Ready outputs derive only from state, so they never follow VALID or READY inputs combinationally.
    assign w_aw_rdy = r_live & ~r_aw_held & ~r_b_valid;
    assign w_w_rdy  = r_live & ~r_w_held & ~r_b_valid;
    assign w_ar_rdy = r_live & (r_rstate == R_IDLE);

    assign w_aw_hs  = s_axi.AW_VALID & w_aw_rdy;
    assign w_w_hs   = s_axi.W_VALID & w_w_rdy;
    assign w_ar_hs  = s_axi.AR_VALID & w_ar_rdy;

    // Commit sources come from the latch if that half arrived earlier, else straight off the bus.
    assign w_c_idx  = r_aw_held ? r_aw_idx : s_axi.AW_ADDR[ADDR_W-1:ALSB];
    assign w_c_data = r_w_held ? r_w_data : s_axi.W_DATA;
    assign w_c_strb = r_w_held ? r_w_strb : s_axi.W_STRB;
    assign w_commit = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    assign w_c_ok   = ({1'b0, w_c_idx} < LIMIT);

    assign w_ar_idx = s_axi.AR_ADDR[ADDR_W-1:ALSB];
    assign w_ar_ok  = ({1'b0, w_ar_idx} < LIMIT);

    assign w_unused = ^{s_axi.AW_PROT, s_axi.AR_PROT,
                        s_axi.AW_ADDR[ALSB-1:0], s_axi.AR_ADDR[ALSB-1:0]};

    // Write channel: latch AW and W independently, commit strobed bytes once both are present.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            r_wstate  <= W_IDLE;
            r_live    <= 1'b0;
            r_aw_held <= 1'b0;
            r_aw_idx  <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_b_valid <= 1'b0;
            r_b_resp  <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= RESET_VAL;
`ifdef AXI4L_WR_PULSE_EN
            r_wr_pulse <= '0;
`endif
        end else begin
            r_live <= 1'b1;
`ifdef AXI4L_WR_PULSE_EN
            r_wr_pulse <= '0;
`endif
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_aw_idx  <= s_axi.AW_ADDR[ADDR_W-1:ALSB];
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_w_data <= s_axi.W_DATA;
                        r_w_strb <= s_axi.W_STRB;
                    end
                    if (w_commit) begin
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_b_valid <= 1'b1;
                        r_b_resp  <= w_c_ok ? RESP_OKAY : RESP_SLVERR;
                        r_wstate  <= W_RESP;
                        if (w_c_ok) begin
                            for (int b = 0; b < NBYTES; b++) begin
                                if (w_c_strb[b])
                                    r_regs[w_c_idx[IDX_W-1:0]][b*8 +: 8] <= w_c_data[b*8 +: 8];
                            end
`ifdef AXI4L_WR_PULSE_EN
                            if (|w_c_strb) r_wr_pulse[w_c_idx[IDX_W-1:0]] <= 1'b1;
`endif
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.B_READY) begin
                        r_b_valid <= 1'b0;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read channel: capture the addressed register on AR handshake, hold it until R handshake.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            r_rstate  <= R_IDLE;
            r_r_valid <= 1'b0;
            r_r_data  <= '0;
            r_r_resp  <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_r_valid <= 1'b1;
                        r_r_data  <= w_ar_ok ? r_regs[w_ar_idx[IDX_W-1:0]] : '0;
                        r_r_resp  <= w_ar_ok ? RESP_OKAY : RESP_SLVERR;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.R_READY) begin
                        r_r_valid <= 1'b0;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.AW_READY = w_aw_rdy;
    assign s_axi.W_READY  = w_w_rdy;
    assign s_axi.B_VALID  = r_b_valid;
    assign s_axi.B_RESP   = r_b_resp;
    assign s_axi.AR_READY = w_ar_rdy;
    assign s_axi.R_VALID  = r_r_valid;
    assign s_axi.R_DATA   = r_r_data;
    assign s_axi.R_RESP   = r_r_resp;
`ifdef AXI4L_WR_PULSE_EN
    assign WR_PULSE = r_wr_pulse;
`endif
endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Directed bench for the AXI4-Lite register slave: table of write/read vectors
// followed by hand-written sequences for ordering, backpressure, collision and reset.
// Outputs are sampled 1 time unit after the rising edge.
module tb_axi4lite_reg_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    axi4lite_reg_slave_if #(.ADDR_W(12), .DATA_W(32)) bus ();
`ifdef AXI4L_WR_PULSE_EN
    logic [15:0] wr_pulse;
`endif

    axi4lite_reg_slave #(.ADDR_W(12), .DATA_W(32), .NUM_REGS(16)) dut (
        .A_CLK (clk),
        .A_RST (rst),
        .s_axi (bus)
`ifdef AXI4L_WR_PULSE_EN
        ,
        .WR_PULSE (wr_pulse)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_rresp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Same-cycle AW+W write; returns B_RESP and checks 1-cycle response latency.
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int n = 0;
        bus.AW_ADDR = a; bus.AW_VALID = 1'b1;
        bus.W_DATA = d;  bus.W_STRB = s; bus.W_VALID = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_now = bus.AW_VALID && bus.AW_READY;
            w_now  = bus.W_VALID && bus.W_READY;
            tick();
            if (aw_now) begin aw_done = 1; bus.AW_VALID = 1'b0; end
            if (w_now)  begin w_done = 1;  bus.W_VALID = 1'b0; end
            n++;
        end
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        if (!(aw_done && w_done)) timeout("wr_handshake");
        chk("b_latency", {31'd0, bus.B_VALID}, 32'd1);
        resp = bus.B_RESP;
        bus.B_READY = 1'b1;
        n = 0;
        while (!bus.B_VALID && n < 20) begin tick(); n++; end
        tick();
        bus.B_READY = 1'b0;
        if (n >= 20) timeout("wr_bresp");
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n = 0;
        bus.AR_ADDR = a; bus.AR_VALID = 1'b1;
        while (!bus.AR_READY && n < 20) begin tick(); n++; end
        tick();
        bus.AR_VALID = 1'b0;
        if (n >= 20) timeout("rd_handshake");
        chk("r_latency", {31'd0, bus.R_VALID}, 32'd1);
        d = bus.R_DATA;
        resp = bus.R_RESP;
        bus.R_READY = 1'b1;
        tick();
        bus.R_READY = 1'b0;
    endtask

    initial begin
        logic [1:0]  br, rr;
        logic [31:0] rdat;

        vecs[0] = '{12'h008, 32'hDEADBEEF, 4'b1111, 2'b00, 32'hDEADBEEF, 2'b00};
        vecs[1] = '{12'h00C, 32'h12345678, 4'b0011, 2'b00, 32'h00005678, 2'b00};
        vecs[2] = '{12'h00D, 32'hAABBCCDD, 4'b1100, 2'b00, 32'hAABB5678, 2'b00};
        vecs[3] = '{12'h040, 32'hFFFFFFFF, 4'b1111, 2'b10, 32'h00000000, 2'b10};
        vecs[4] = '{12'h03C, 32'h0F0F0F0F, 4'b1000, 2'b00, 32'h0F000000, 2'b00};
        vecs[5] = '{12'h010, 32'hFFFFFFFF, 4'b0000, 2'b00, 32'h00000000, 2'b00};
        vecs[6] = '{12'h3FC, 32'h12345678, 4'b1111, 2'b10, 32'h00000000, 2'b10};

        bus.AW_VALID = 0; bus.AW_ADDR = '0; bus.AW_PROT = '0;
        bus.W_VALID = 0;  bus.W_DATA = '0;  bus.W_STRB = '0;
        bus.B_READY = 0;
        bus.AR_VALID = 0; bus.AR_ADDR = '0; bus.AR_PROT = '0;
        bus.R_READY = 0;

        repeat (3) tick();
        chk("rst_aw_ready", {31'd0, bus.AW_READY}, 32'd0);
        chk("rst_w_ready",  {31'd0, bus.W_READY},  32'd0);
        chk("rst_ar_ready", {31'd0, bus.AR_READY}, 32'd0);
        chk("rst_b_valid",  {31'd0, bus.B_VALID},  32'd0);
        chk("rst_r_valid",  {31'd0, bus.R_VALID},  32'd0);
        chk("rst_b_resp",   {30'd0, bus.B_RESP},   32'd0);
        chk("rst_r_resp",   {30'd0, bus.R_RESP},   32'd0);
        chk("rst_r_data",   bus.R_DATA,            32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_aw_ready", {31'd0, bus.AW_READY}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            wr(vecs[i].addr, vecs[i].wdata, vecs[i].strb, br);
            chk($sformatf("vec%0d_bresp", i), {30'd0, br}, {30'd0, vecs[i].exp_bresp});
            rd(vecs[i].addr, rdat, rr);
            chk($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rresp", i), {30'd0, rr}, {30'd0, vecs[i].exp_rresp});
        end

        // W arrives three cycles ahead of AW.
        bus.W_DATA = 32'h11223344; bus.W_STRB = 4'b0101; bus.W_VALID = 1'b1;
        tick();
        bus.W_VALID = 1'b0;
        chk("wfirst_w_ready_low", {31'd0, bus.W_READY}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("wfirst_no_b", {31'd0, bus.B_VALID}, 32'd0);
            tick();
        end
        bus.AW_ADDR = 12'h008; bus.AW_VALID = 1'b1;
        tick();
        bus.AW_VALID = 1'b0;
        chk("wfirst_b_valid", {31'd0, bus.B_VALID}, 32'd1);
        chk("wfirst_b_resp",  {30'd0, bus.B_RESP},  32'd0);
`ifdef AXI4L_WR_PULSE_EN
        chk("wr_pulse_on", {16'd0, wr_pulse}, 32'h0000_0004);
`endif
        bus.B_READY = 1'b1;
        tick();
        bus.B_READY = 1'b0;
`ifdef AXI4L_WR_PULSE_EN
        chk("wr_pulse_off", {16'd0, wr_pulse}, 32'd0);
`endif
        rd(12'h008, rdat, rr);
        chk("wfirst_rdata", rdat, 32'hDE22BE44);

        // B backpressure.
        bus.AW_ADDR = 12'h018; bus.AW_VALID = 1'b1;
        bus.W_DATA = 32'h1; bus.W_STRB = 4'hF; bus.W_VALID = 1'b1;
        tick();
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bstall_b_valid",  {31'd0, bus.B_VALID},  32'd1);
            chk("bstall_aw_ready", {31'd0, bus.AW_READY}, 32'd0);
            chk("bstall_w_ready",  {31'd0, bus.W_READY},  32'd0);
            tick();
        end
        bus.B_READY = 1'b1;
        tick();
        bus.B_READY = 1'b0;
        chk("bstall_released", {31'd0, bus.B_VALID}, 32'd0);

        // R backpressure.
        bus.AR_ADDR = 12'h008; bus.AR_VALID = 1'b1;
        tick();
        bus.AR_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("rstall_r_valid",  {31'd0, bus.R_VALID},  32'd1);
            chk("rstall_r_data",   bus.R_DATA,            32'hDE22BE44);
            chk("rstall_ar_ready", {31'd0, bus.AR_READY}, 32'd0);
            tick();
        end
        bus.R_READY = 1'b1;
        tick();
        bus.R_READY = 1'b0;
        chk("rstall_released", {31'd0, bus.R_VALID}, 32'd0);

        // Read capture and write commit on the same edge to the same register.
        bus.AR_ADDR = 12'h004; bus.AR_VALID = 1'b1;
        bus.AW_ADDR = 12'h004; bus.AW_VALID = 1'b1;
        bus.W_DATA = 32'hA5A5A5A5; bus.W_STRB = 4'hF; bus.W_VALID = 1'b1;
        tick();
        bus.AR_VALID = 1'b0; bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        chk("coll_r_valid", {31'd0, bus.R_VALID}, 32'd1);
        chk("coll_b_valid", {31'd0, bus.B_VALID}, 32'd1);
        chk("coll_old_data", bus.R_DATA, 32'd0);
        bus.B_READY = 1'b1; bus.R_READY = 1'b1;
        tick();
        bus.B_READY = 1'b0; bus.R_READY = 1'b0;
        rd(12'h004, rdat, rr);
        chk("coll_new_data", rdat, 32'hA5A5A5A5);

        // Reset while a write response is pending.
        bus.AW_ADDR = 12'h008; bus.AW_VALID = 1'b1;
        bus.W_DATA = 32'h55; bus.W_STRB = 4'hF; bus.W_VALID = 1'b1;
        tick();
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        chk("rstmid_b_pending", {31'd0, bus.B_VALID}, 32'd1);
        rst = 1'b1;
        tick();
        chk("rstmid_b_dropped", {31'd0, bus.B_VALID}, 32'd0);
        chk("rstmid_aw_ready",  {31'd0, bus.AW_READY}, 32'd0);
        rst = 1'b0;
        tick();
        rd(12'h008, rdat, rr);
        chk("rstmid_reg2", rdat, 32'd0);
        rd(12'h004, rdat, rr);
        chk("rstmid_reg1", rdat, 32'd0);
        chk("rstmid_no_b", {31'd0, bus.B_VALID}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
